multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Moore-style FSM that sequences the multi-cycle MIPS datapath through fetch, decode, execute, memory and writeback phases. One shared ALU and one unified instruction/data memory are reused across cycles. The FSM emits per-cycle datapath strobes and handshakes with memory via mem_ready. It replaces the single-cycle combinational control path for the multi-cycle CPU build.

Parameters:
STATE_W, 4, width of state register / debug state output
DATA_W, 32, datapath width (documentation only; no internal datapath)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
op  in  6  IR[31:26]; stable from DECODE until next FETCH completes
func  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes current access this cycle
pc_en  out  1  PC register write enable
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
i_or_d  out  1  0 address=PC, 1 address=ALUOut
mem_read  out  1  memory read request, held until mem_ready
mem_write  out  1  memory write request, held until mem_ready
ir_write  out  1  IR load
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
instr_done  out  1  one-cycle pulse on last cycle of each instruction
illegal  out  1  one-cycle pulse, unsupported opcode/func
state  out  STATE_W  current state (debug)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. While rst=1 all strobe outputs are forced 0 and alu_op=000; the state register loads FETCH on the edge. rst mid-instruction aborts it with no writes, PC or register.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE, RWB, BRANCH, IEXE, IWB, JUMP.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00. ir_write and pc_en assert only in the cycle mem_ready=1, then go to DECODE; otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut).
  - op 100011/101011 -> MEMADR; 000000 -> REXE; 000100 -> BRANCH; 001000 -> IEXE; 000010 -> JUMP.
  - Other op: illegal=1, instr_done=1, -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, add -> MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, i_or_d=1; on mem_ready -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1; on mem_ready: instr_done=1 -> FETCH.
- REXE: alu_src_a=1, alu_src_b=00. alu_op from func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown func: illegal=1, instr_done=1 -> FETCH with no write.
  - Otherwise -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero, instr_done=1 -> FETCH.
- IEXE: alu_src_a=1, alu_src_b=10, add -> IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1 -> FETCH.
- Outputs not listed for a state are 0 (alu_op=000).
- Cycle counts with mem_ready always 1: R 4, lw 5, sw 4, beq 3, addi 4, j 3. Each mem_ready stall cycle adds 1.
- mem_ready in states with no request is ignored. mem_read and mem_write are never both 1.

Decomposition:
- Shared package mc_pkg holds:
  - state encoding localparams
  - opcode constants: R, LW, SW, BEQ, ADDI, J
  - func constants
  - ALU op codes
  - alu_src_b and pc_src codes
- One sub-module, mc_alu_dec: combinational func -> alu_op plus a valid flag, used in REXE.

Test Plan:
- rst=1 for 2 cycles during MEMRD with mem_ready=0 -> all strobes 0; after release state=FETCH with mem_read=1; no reg_write seen.
- add (op 000000, func 100000), mem_ready=1 -> states FETCH,DECODE,REXE,RWB; alu_op=000 in REXE; reg_write=1, reg_dst=1 in RWB; instr_done pulses exactly once (cycle 4).
- lw with mem_ready low 3 cycles in MEMRD -> mem_read/i_or_d held 4 cycles; MEMWB reached on the 8th cycle; mem_to_reg=1.
- beq with zero=1 then zero=0 -> pc_en=1, pc_src=01 in BRANCH for the first; pc_en=0 for the second; both take 3 cycles.
- op 111111 -> illegal pulse in DECODE, return to FETCH, no reg_write/mem_write. R-type func 000000 -> illegal in REXE, RWB never entered.
- j followed by sw -> pc_src=10, pc_en=1 in JUMP; sw: mem_write held until mem_ready, then FETCH; mem_read never asserted in MEMWR.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
package mc_pkg;

  localparam int ST_BITS = 4;

  // FSM state encoding; also exported on the debug state port.
  typedef enum logic [ST_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC next-value select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type function field to ALU operation decoder; valid=0 flags an unsupported func.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       valid
);

  // Map func to ALU op; unknown codes leave alu_op at add and drop valid
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the multi-cycle MIPS datapath
// (fetch / decode / execute / memory / writeback) with a shared ALU and memory.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  // The jump target {PC[31:28],IR[25:0],2'b00} only makes sense for a 32-bit datapath.
  if (DATA_W != 32) begin : g_bad_data_w
    $error("multicycle_ctrl: DATA_W must be 32");
  end

  state_e     state_q, state_d;
  logic [2:0] dec_alu_op;
  logic       dec_valid;

  mc_alu_dec u_alu_dec (
    .func   (func),
    .alu_op (dec_alu_op),
    .valid  (dec_valid)
  );

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state strobes; reset forces every strobe low so an
  // aborted instruction never writes the PC, register file or memory.
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut while decoding.
          alu_src_b = SRCB_IMM_SH2;
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_REXE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_IEXE;
            OP_J:         state_d = S_JUMP;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_REXE: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_op    = dec_alu_op;
          if (dec_valid) begin
            state_d = S_RWB;
          end else begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_B;
          alu_op     = ALU_SUB;
          pc_src     = PCSRC_ALUOUT;
          pc_en      = zero;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_IEXE: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_IWB;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = PCSRC_JUMP;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle state and strobe checks.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe bundle: pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
  // mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal
  logic [17:0] strobes;
  assign strobes = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3;
  localparam logic [3:0] MEMWB = 4'd4, MEMWR = 4'd5, REXE = 4'd6, RWB = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8, IEXE = 4'd9, IWB = 4'd10, JUMP = 4'd11;

  //                                pe  pcs   iod  mrd  mwr  irw  rdst m2r  rw   a    b      aop     done ill
  localparam logic [17:0] E_ZERO       = 18'd0;
  localparam logic [17:0] E_FETCH_WAIT = {1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_FETCH_GO   = {1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_DECODE     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_DECODE_ILL = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,1'b1,1'b1};
  localparam logic [17:0] E_MEMADR     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MEMRD      = {1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MEMWB      = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [17:0] E_MEMWR_WAIT = {1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MEMWR_GO   = {1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [17:0] E_REXE_ADD   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_REXE_SUB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b0,1'b0};
  localparam logic [17:0] E_REXE_AND   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,1'b0,1'b0};
  localparam logic [17:0] E_REXE_OR    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b011,1'b0,1'b0};
  localparam logic [17:0] E_REXE_SLT   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,1'b0,1'b0};
  localparam logic [17:0] E_REXE_ILL   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,1'b1,1'b1};
  localparam logic [17:0] E_RWB        = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [17:0] E_BR_TAKEN   = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b1,1'b0};
  localparam logic [17:0] E_BR_NOT     = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b1,1'b0};
  localparam logic [17:0] E_IEXE       = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_IWB        = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [17:0] E_JUMP       = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1,1'b0};

  multicycle_ctrl #(.STATE_W(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply per-cycle inputs and let combinational outputs settle
  task automatic drive(input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (state !== FETCH) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, FETCH); end
    n_cmp++; if (strobes !== E_ZERO) begin n_bad++; $display("FAIL reset_strobes: got %b want %b", strobes, E_ZERO); end
    rst = 1'b0;
    op = 6'b100011;
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0);
    n_cmp++; if (state !== MEMRD) begin n_bad++; $display("FAIL reset_pre_state: got %0d want %0d", state, MEMRD); end
    n_cmp++; if (strobes !== E_MEMRD) begin n_bad++; $display("FAIL reset_pre_strobes: got %b want %b", strobes, E_MEMRD); end
    rst = 1'b1;
    #1;
    n_cmp++; if (strobes !== E_ZERO) begin n_bad++; $display("FAIL reset_mid1_strobes: got %b want %b", strobes, E_ZERO); end
    tick();
    n_cmp++; if (strobes !== E_ZERO) begin n_bad++; $display("FAIL reset_mid2_strobes: got %b want %b", strobes, E_ZERO); end
    n_cmp++; if (state !== FETCH) begin n_bad++; $display("FAIL reset_mid2_state: got %0d want %0d", state, FETCH); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    n_cmp++; if (state !== FETCH) begin n_bad++; $display("FAIL reset_rel_state: got %0d want %0d", state, FETCH); end
    n_cmp++; if (strobes !== E_FETCH_WAIT) begin n_bad++; $display("FAIL reset_rel_strobes: got %b want %b", strobes, E_FETCH_WAIT); end
    tick();
    drive(1'b0, 1'b0);
    n_cmp++; if (state !== FETCH) begin n_bad++; $display("FAIL reset_hold_state: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_add();
    logic [3:0]  st [4];
    logic [17:0] ev [4];
    st = '{FETCH, DECODE, REXE, RWB};
    ev = '{E_FETCH_GO, E_DECODE, E_REXE_ADD, E_RWB};
    op = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++; if (state !== st[i]) begin n_bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (strobes !== ev[i]) begin n_bad++; $display("FAIL add_strobes[%0d]: got %b want %b", i, strobes, ev[i]); end
      tick();
    end
  endtask

  task automatic test_r_ops();
    logic [5:0]  fn [4];
    logic [17:0] ex [4];
    fn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ex = '{E_REXE_SUB, E_REXE_AND, E_REXE_OR, E_REXE_SLT};
    op = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      func = fn[k];
      drive(1'b1, 1'b0); tick();
      drive(1'b1, 1'b0); tick();
      drive(1'b1, 1'b0);
      n_cmp++; if (strobes !== ex[k]) begin n_bad++; $display("FAIL rops_rexe[%0d]: got %b want %b", k, strobes, ex[k]); end
      tick();
      drive(1'b1, 1'b0);
      n_cmp++; if (strobes !== E_RWB) begin n_bad++; $display("FAIL rops_rwb[%0d]: got %b want %b", k, strobes, E_RWB); end
      tick();
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  st [8];
    logic [17:0] ev [8];
    logic        mr [8];
    st = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMRD, MEMWB};
    ev = '{E_FETCH_GO, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      drive(mr[i], 1'b0);
      n_cmp++; if (state !== st[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (strobes !== ev[i]) begin n_bad++; $display("FAIL lw_strobes[%0d]: got %b want %b", i, strobes, ev[i]); end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [3:0]  st [6];
    logic [17:0] ev [6];
    logic        mr [6];
    logic        zf [6];
    st = '{FETCH, DECODE, BRANCH, FETCH, DECODE, BRANCH};
    ev = '{E_FETCH_GO, E_DECODE, E_BR_TAKEN, E_FETCH_GO, E_DECODE, E_BR_NOT};
    mr = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    zf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    op = 6'b000100;
    for (int i = 0; i < 6; i++) begin
      drive(mr[i], zf[i]);
      n_cmp++; if (state !== st[i]) begin n_bad++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (strobes !== ev[i]) begin n_bad++; $display("FAIL beq_strobes[%0d]: got %b want %b", i, strobes, ev[i]); end
      tick();
    end
  endtask

  task automatic test_addi();
    logic [3:0]  st [5];
    logic [17:0] ev [5];
    logic        mr [5];
    st = '{FETCH, FETCH, DECODE, IEXE, IWB};
    ev = '{E_FETCH_WAIT, E_FETCH_GO, E_DECODE, E_IEXE, E_IWB};
    mr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      drive(mr[i], 1'b0);
      n_cmp++; if (state !== st[i]) begin n_bad++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (strobes !== ev[i]) begin n_bad++; $display("FAIL addi_strobes[%0d]: got %b want %b", i, strobes, ev[i]); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [6];
    logic [17:0] ev [6];
    logic [5:0]  ops [6];
    logic        mr [6];
    st  = '{FETCH, DECODE, FETCH, DECODE, REXE, FETCH};
    ev  = '{E_FETCH_GO, E_DECODE_ILL, E_FETCH_GO, E_DECODE, E_REXE_ILL, E_FETCH_WAIT};
    ops = '{6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    func = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      op = ops[i];
      drive(mr[i], 1'b0);
      n_cmp++; if (state !== st[i]) begin n_bad++; $display("FAIL ill_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (strobes !== ev[i]) begin n_bad++; $display("FAIL ill_strobes[%0d]: got %b want %b", i, strobes, ev[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  st [10];
    logic [17:0] ev [10];
    logic [5:0]  ops [10];
    logic        mr [10];
    st  = '{FETCH, DECODE, JUMP, FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR, FETCH};
    ev  = '{E_FETCH_GO, E_DECODE, E_JUMP, E_FETCH_GO, E_DECODE, E_MEMADR,
            E_MEMWR_WAIT, E_MEMWR_WAIT, E_MEMWR_GO, E_FETCH_WAIT};
    ops = '{6'b000010, 6'b000010, 6'b000010, 6'b101011, 6'b101011,
            6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011};
    mr  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      op = ops[i];
      drive(mr[i], 1'b0);
      n_cmp++; if (state !== st[i]) begin n_bad++; $display("FAIL jsw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (strobes !== ev[i]) begin n_bad++; $display("FAIL jsw_strobes[%0d]: got %b want %b", i, strobes, ev[i]); end
      tick();
    end
  endtask

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed test sequence
  initial begin
    test_reset();
    test_add();
    test_r_ops();
    test_lw_stall();
    test_beq();
    test_addi();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
